bti_arbiter: RTL and testbench
==============================

BTI_ARBITER -- requirements
Module: bti_arbiter

Interface
REQ-001 Parameter BTI_AW, default 32: request address width.
REQ-002 Parameter BTI_DW, default 32: data width; strobe width is BTI_DW/8.
REQ-003 Parameter OSTD_DEPTH, default 4: maximum outstanding requests; power of two, 2..16.
REQ-004 Port clk, in, 1: single clock, rising-edge.
REQ-005 Port rst_n, in, 1: asynchronous active-low reset.
REQ-006 Ports h0_req_vld/h1_req_vld, in, 1: host request valid.
REQ-007 Ports h0_req_rdy/h1_req_rdy, out, 1: host request accepted.
REQ-008 Ports h0_req_addr/h1_req_addr (in, BTI_AW), hN_req_wr (in, 1; 1=write), hN_req_wdata (in, BTI_DW), hN_req_strb (in, BTI_DW/8): request payload.
REQ-009 Ports h0_rsp_vld/h1_rsp_vld, out, 1; hN_rsp_rdy, in, 1; hN_rsp_rdata, out, BTI_DW: response channel per host.
REQ-010 Ports g_req_vld (out), g_req_rdy (in), g_req_addr/wr/wdata/strb (out): shared guest request channel.
REQ-011 Ports g_rsp_vld (in), g_rsp_rdy (out), g_rsp_rdata (in, BTI_DW): shared guest response channel.

Function
REQ-012 A handshake occurs on any channel when vld and rdy are both 1 on a rising clk edge.
REQ-013 Arbitration is combinational: g_req_vld = vld of the granted host; g_req payload = payload of the granted host.
REQ-014 Grant selection with no lock: if only one host is valid, that host is granted; if both are valid, the host indicated by the priority pointer prio (0 or 1) is granted.
REQ-015 Lock rule: when g_req_vld=1 and no guest handshake occurs, the lock register is set to the granted host, and grant holds on that host until its handshake; the arbiter never switches grant while a request is pending.
REQ-016 hN_req_rdy = (grant==N) & g_req_rdy & ~ostd_full; g_req_vld = 0 while ostd_full=1.
REQ-017 On each guest request handshake, the granted host ID (1 bit) is pushed into an ID FIFO of depth OSTD_DEPTH, and prio is set to the other host.
REQ-018 Response routing: the FIFO head ID selects the destination. h[head]_rsp_vld = g_rsp_vld & ~ostd_empty; g_rsp_rdy = h[head]_rsp_rdy & ~ostd_empty. The other host's rsp_vld = 0.
REQ-019 hN_rsp_rdata = g_rsp_rdata for both hosts.
REQ-020 On each guest response handshake, the FIFO head is popped.
REQ-021 Push and pop in the same cycle: both take effect and the count is unchanged. When full, a push is blocked by REQ-016 even if a pop occurs that cycle.
REQ-022 g_rsp_vld with an empty FIFO is ignored: g_rsp_rdy=0 and it is flagged under the assertion option.
REQ-023 Latency: 0 added cycles on both request and response paths (combinational pass-through).
REQ-024 FIFO pointers wrap modulo OSTD_DEPTH; the count is $clog2(OSTD_DEPTH)+1 bits wide.

Reset
REQ-025 While rst_n=0: FIFO empty, count=0, prio=0, lock cleared; hence g_req_vld=0, g_rsp_rdy=0, hN_rsp_vld=0, hN_req_rdy=0.
REQ-026 Reset asserted mid-transaction discards all outstanding IDs; the guest is reset by the same rst_n.
REQ-027 After reset release, the first cycle follows REQ-014 with prio=0.

Configuration
REQ-028 Macro BTI_ARB_RR_EN defined: round-robin as in REQ-014/017.
REQ-029 Macro BTI_ARB_RR_EN undefined: fixed priority, host 0 always wins contention; prio is not implemented; the lock rule REQ-015 still applies.

Verification
REQ-030 Both hosts valid every cycle, g_req_rdy=1, guest responds 1 cycle later: grants alternate h0,h1,h0,h1; each response reaches the issuing host (rdata=addr echo).
REQ-031 OSTD_DEPTH=4, guest never responds: 4 handshakes accepted, then g_req_vld=0 and hN_req_rdy=0; one response restores exactly one further accept.
REQ-032 h1 valid with g_req_rdy=0 for 3 cycles, h0 raises valid in cycle 2: grant stays h1 until its handshake, then h0 is granted.
REQ-033 FIFO full, g_rsp handshake and a pending h0 request in the same cycle: no push that cycle; push occurs next cycle with count back to 4.
REQ-034 rst_n pulsed low with 3 outstanding: all outputs 0 immediately (asynchronous); after release, count=0 and h0 wins first contention.
REQ-035 BTI_ARB_RR_EN undefined, both hosts valid continuously: h0 granted every cycle and h1 starved.

Source files
------------

// File: rtl/bti_arbiter_if.sv
// Request/response bus shared by the arbiter's host ports and its guest port.
// The master drives requests and accepts responses; the slave does the reverse.
interface bti_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic            req_vld;
    logic            req_rdy;
    logic [AW-1:0]   req_addr;
    logic            req_wr;
    logic [DW-1:0]   req_wdata;
    logic [DW/8-1:0] req_strb;
    logic            rsp_vld;
    logic            rsp_rdy;
    logic [DW-1:0]   rsp_rdata;

    modport master (
        output req_vld, req_addr, req_wr, req_wdata, req_strb, rsp_rdy,
        input  req_rdy, rsp_vld, rsp_rdata
    );

    modport slave (
        input  req_vld, req_addr, req_wr, req_wdata, req_strb, rsp_rdy,
        output req_rdy, rsp_vld, rsp_rdata
    );
endinterface

// File: rtl/bti_arbiter.sv
// Two-host to one-guest bus arbiter with an in-order ID FIFO for response routing.
// BTI_ARB_RR_EN selects round-robin (default: fixed priority, host 0 wins); BTI_ARB_ASSERT adds a stray-response check.
module bti_arbiter #(
    parameter int BTI_AW     = 32,
    parameter int BTI_DW     = 32,
    parameter int OSTD_DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    bti_arbiter_if.slave   h0,
    bti_arbiter_if.slave   h1,
    bti_arbiter_if.master  g
);
    localparam int PW = $clog2(OSTD_DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          lock_vld_q, lock_vld_d;
    logic          lock_id_q, lock_id_d;
    logic          id_q [OSTD_DEPTH];

    logic              grant;
    logic              contend_pick;
    logic              ostd_full;
    logic              ostd_empty;
    logic              head_id;
    logic              push;
    logic              pop;
    logic              sel_vld;
    logic [BTI_AW-1:0] sel_addr;
    logic              sel_wr;
    logic [BTI_DW-1:0] sel_wdata;
    logic [BTI_DW/8-1:0] sel_strb;

`ifdef BTI_ARB_RR_EN
    logic prio_q, prio_d;
    assign contend_pick = prio_q;
`else
    assign contend_pick = 1'b0;
`endif

    always_comb begin
        ostd_full  = (count_q == CW'(OSTD_DEPTH));
        ostd_empty = (count_q == '0);
        // A pending (unaccepted) request pins the grant until it hands off.
        if (lock_vld_q) begin
            grant = lock_id_q;
        end else if (h0.req_vld && h1.req_vld) begin
            grant = contend_pick;
        end else begin
            grant = h1.req_vld;
        end
        sel_vld   = grant ? h1.req_vld   : h0.req_vld;
        sel_addr  = grant ? h1.req_addr  : h0.req_addr;
        sel_wr    = grant ? h1.req_wr    : h0.req_wr;
        sel_wdata = grant ? h1.req_wdata : h0.req_wdata;
        sel_strb  = grant ? h1.req_strb  : h0.req_strb;
        head_id   = id_q[rd_ptr_q];
    end

    // Outputs are gated by rst_n so the bus goes quiet the moment reset asserts.
    assign g.req_vld   = rst_n & ~ostd_full & sel_vld;
    assign g.req_addr  = sel_addr;
    assign g.req_wr    = sel_wr;
    assign g.req_wdata = sel_wdata;
    assign g.req_strb  = sel_strb;
    assign h0.req_rdy  = rst_n & ~grant & g.req_rdy & ~ostd_full;
    assign h1.req_rdy  = rst_n &  grant & g.req_rdy & ~ostd_full;

    assign h0.rsp_vld   = rst_n & g.rsp_vld & ~ostd_empty & ~head_id;
    assign h1.rsp_vld   = rst_n & g.rsp_vld & ~ostd_empty &  head_id;
    assign g.rsp_rdy    = rst_n & ~ostd_empty & (head_id ? h1.rsp_rdy : h0.rsp_rdy);
    assign h0.rsp_rdata = g.rsp_rdata;
    assign h1.rsp_rdata = g.rsp_rdata;

    assign push = g.req_vld & g.req_rdy;
    assign pop  = g.rsp_vld & g.rsp_rdy;

    always_comb begin
        wr_ptr_d   = wr_ptr_q + PW'(push);
        rd_ptr_d   = rd_ptr_q + PW'(pop);
        count_d    = count_q + CW'(push) - CW'(pop);
        lock_vld_d = lock_vld_q;
        lock_id_d  = lock_id_q;
        if (push) begin
            lock_vld_d = 1'b0;
        end else if (g.req_vld) begin
            lock_vld_d = 1'b1;
            lock_id_d  = grant;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            lock_vld_q <= 1'b0;
            lock_id_q  <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            lock_vld_q <= lock_vld_d;
            lock_id_q  <= lock_id_d;
        end
    end

`ifdef BTI_ARB_RR_EN
    always_comb begin
        prio_d = push ? ~grant : prio_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end
`endif

    for (genvar gi = 0; gi < OSTD_DEPTH; gi++) begin : g_id_fifo
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                id_q[gi] <= 1'b0;
            end else if (push && (wr_ptr_q == PW'(gi))) begin
                id_q[gi] <= grant;
            end
        end
    end

`ifdef BTI_ARB_ASSERT
    a_rsp_when_empty: assert property (@(posedge clk) disable iff (!rst_n) !(g.rsp_vld && ostd_empty))
        else $error("bti_arbiter: guest response with no outstanding request");
`endif
endmodule

// File: tb/tb_bti_arbiter.sv
// Self-checking bench for bti_arbiter: directed scenarios plus a randomized run
// compared against a queue-based model of outstanding requests.
module tb_bti_arbiter;
    localparam int DEPTH = 4;
`ifdef BTI_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bti_arbiter_if #(.AW(32), .DW(32)) h0_if ();
    bti_arbiter_if #(.AW(32), .DW(32)) h1_if ();
    bti_arbiter_if #(.AW(32), .DW(32)) g_if ();

    bti_arbiter #(.BTI_AW(32), .BTI_DW(32), .OSTD_DEPTH(DEPTH)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .h0   (h0_if),
        .h1   (h1_if),
        .g    (g_if)
    );

    int checks = 0;
    int failures = 0;

    // Model: FIFO of issuing host IDs, priority pointer, and pending-grant lock (-1 = none).
    int m_q[$];
    int m_prio;
    int m_lock;

    task automatic set_idle();
        h0_if.req_vld = 0; h0_if.req_addr = '0; h0_if.req_wr = 0; h0_if.req_wdata = '0; h0_if.req_strb = '0; h0_if.rsp_rdy = 0;
        h1_if.req_vld = 0; h1_if.req_addr = '0; h1_if.req_wr = 0; h1_if.req_wdata = '0; h1_if.req_strb = '0; h1_if.rsp_rdy = 0;
        g_if.req_rdy = 0; g_if.rsp_vld = 0; g_if.rsp_rdata = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        set_idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_q.delete();
        m_prio = 0;
        m_lock = -1;
    endtask

    task automatic test_reset();
        logic [5:0] got;
        set_idle();
        h0_if.req_vld = 1; h1_if.req_vld = 1; g_if.req_rdy = 1;
        g_if.rsp_vld = 1; h0_if.rsp_rdy = 1; h1_if.rsp_rdy = 1;
        rst_n = 1'b0;
        #1;
        got = {g_if.req_vld, h0_if.req_rdy, h1_if.req_rdy, g_if.rsp_rdy, h0_if.rsp_vld, h1_if.rsp_vld};
        checks++;
        if (got !== 6'b000000) begin
            failures++;
            $display("FAIL reset_outputs: got %b expected 000000", got);
        end
        next_cycle();
        rst_n = 1'b1;
        #3;
        got = {g_if.req_vld, h0_if.req_rdy, h1_if.req_rdy, g_if.rsp_rdy, h0_if.rsp_vld, h1_if.rsp_vld};
        checks++;
        if (got !== 6'b110000) begin
            failures++;
            $display("FAIL reset_first_grant: got %b expected 110000", got);
        end
        $display("test_reset: done");
    endtask

    task automatic test_contention();
        logic [31:0] rsp_q[$];
        logic [31:0] exp_addr;
        int exp_g;
        int prev_g = -1;
        apply_reset();
        for (int k = 0; k < 12; k++) begin
            h0_if.req_vld = 1; h0_if.req_addr = 32'h1000 + k; h0_if.req_wdata = k; h0_if.req_strb = 4'hF;
            h1_if.req_vld = 1; h1_if.req_addr = 32'h2000 + k; h1_if.req_wdata = k; h1_if.req_strb = 4'hF;
            h0_if.rsp_rdy = 1; h1_if.rsp_rdy = 1; g_if.req_rdy = 1;
            g_if.rsp_vld = (rsp_q.size() > 0);
            g_if.rsp_rdata = (rsp_q.size() > 0) ? rsp_q[0] : 32'h0;
            exp_g = RR ? (k % 2) : 0;
            exp_addr = (exp_g == 1) ? 32'h2000 + k : 32'h1000 + k;
            #3;
            checks++;
            if ({g_if.req_addr, h0_if.req_rdy, h1_if.req_rdy} !== {exp_addr, exp_g == 0, exp_g == 1}) begin
                failures++;
                $display("FAIL contention_grant[%0d]: got addr=%h rdy=%b%b expected addr=%h host=%0d",
                         k, g_if.req_addr, h0_if.req_rdy, h1_if.req_rdy, exp_addr, exp_g);
            end
            if (prev_g >= 0) begin
                checks++;
                if ({h0_if.rsp_vld, h1_if.rsp_vld} !== {prev_g == 0, prev_g == 1} ||
                    (prev_g == 0 ? h0_if.rsp_rdata : h1_if.rsp_rdata) !== rsp_q[0]) begin
                    failures++;
                    $display("FAIL contention_rsp[%0d]: got vld=%b%b expected host=%0d rdata=%h",
                             k, h0_if.rsp_vld, h1_if.rsp_vld, prev_g, rsp_q[0]);
                end
                void'(rsp_q.pop_front());
            end
            rsp_q.push_back(exp_addr);
            prev_g = exp_g;
            $display("test_contention: cycle %0d grant h%0d addr %h", k, exp_g, exp_addr);
            next_cycle();
        end
        set_idle();
    endtask

    task automatic test_lock();
        apply_reset();
        h1_if.req_vld = 1; h1_if.req_addr = 32'hB1B1_0001; h1_if.req_wr = 1; h1_if.req_wdata = 32'h1111; h1_if.req_strb = 4'h3;
        h0_if.req_addr = 32'hA0A0_0000; h0_if.req_wdata = 32'h2222; h0_if.req_strb = 4'hC;
        for (int c = 0; c < 5; c++) begin
            h0_if.req_vld = (c >= 1);
            if (c == 4) h1_if.req_vld = 0;
            g_if.req_rdy = (c >= 3);
            #3;
            checks++;
            if (c < 4) begin
                if ({g_if.req_vld, g_if.req_addr, g_if.req_wr, g_if.req_strb, h0_if.req_rdy, h1_if.req_rdy} !==
                    {1'b1, 32'hB1B1_0001, 1'b1, 4'h3, 1'b0, c == 3}) begin
                    failures++;
                    $display("FAIL lock_hold[%0d]: got addr=%h rdy=%b%b expected addr=b1b10001 rdy=0%b",
                             c, g_if.req_addr, h0_if.req_rdy, h1_if.req_rdy, c == 3);
                end
            end else begin
                if ({g_if.req_vld, g_if.req_addr, g_if.req_wdata, h0_if.req_rdy, h1_if.req_rdy} !==
                    {1'b1, 32'hA0A0_0000, 32'h2222, 1'b1, 1'b0}) begin
                    failures++;
                    $display("FAIL lock_release: got addr=%h rdy=%b%b expected addr=a0a00000 rdy=10",
                             g_if.req_addr, h0_if.req_rdy, h1_if.req_rdy);
                end
            end
            $display("test_lock: cycle %0d g_req_addr %h", c, g_if.req_addr);
            next_cycle();
        end
        set_idle();
    endtask

    task automatic test_ostd_full();
        apply_reset();
        h0_if.req_vld = 1; h0_if.rsp_rdy = 1; g_if.req_rdy = 1;
        for (int k = 0; k < 6; k++) begin
            h0_if.req_addr = k;
            #3;
            checks++;
            if ({g_if.req_vld, h0_if.req_rdy, h1_if.req_rdy} !== {k < 4, k < 4, 1'b0}) begin
                failures++;
                $display("FAIL ostd_fill[%0d]: got vld/rdy=%b%b expected %b", k, g_if.req_vld, h0_if.req_rdy, k < 4);
            end
            $display("test_ostd_full: fill cycle %0d accept=%b", k, h0_if.req_rdy);
            next_cycle();
        end
        g_if.rsp_vld = 1; g_if.rsp_rdata = 32'hABCD;
        #3;
        checks++;
        if ({g_if.req_vld, h0_if.req_rdy, g_if.rsp_rdy, h0_if.rsp_vld, h0_if.rsp_rdata} !== {4'b0011, 32'hABCD}) begin
            failures++;
            $display("FAIL ostd_pop_while_full: got %b%b%b%b expected 0011", g_if.req_vld, h0_if.req_rdy, g_if.rsp_rdy, h0_if.rsp_vld);
        end
        $display("test_ostd_full: pop while full");
        next_cycle();
        g_if.rsp_vld = 0;
        #3;
        checks++;
        if ({g_if.req_vld, h0_if.req_rdy} !== 2'b11) begin
            failures++;
            $display("FAIL ostd_refill: got %b%b expected 11", g_if.req_vld, h0_if.req_rdy);
        end
        $display("test_ostd_full: one further accept");
        next_cycle();
        #3;
        checks++;
        if ({g_if.req_vld, h0_if.req_rdy} !== 2'b00) begin
            failures++;
            $display("FAIL ostd_full_again: got %b%b expected 00", g_if.req_vld, h0_if.req_rdy);
        end
        next_cycle();
        set_idle();
    endtask

    task automatic test_reset_mid();
        logic [5:0] got;
        apply_reset();
        h0_if.req_vld = 1; g_if.req_rdy = 1;
        repeat (3) next_cycle();
        h1_if.req_vld = 1; g_if.req_rdy = 0; g_if.rsp_vld = 1; h0_if.rsp_rdy = 1;
        #1;
        checks++;
        if ({g_if.rsp_rdy, h0_if.rsp_vld} !== 2'b11) begin
            failures++;
            $display("FAIL midreset_outstanding: got %b%b expected 11", g_if.rsp_rdy, h0_if.rsp_vld);
        end
        rst_n = 1'b0;
        #1;
        got = {g_if.req_vld, h0_if.req_rdy, h1_if.req_rdy, g_if.rsp_rdy, h0_if.rsp_vld, h1_if.rsp_vld};
        checks++;
        if (got !== 6'b000000) begin
            failures++;
            $display("FAIL midreset_async: got %b expected 000000", got);
        end
        next_cycle();
        rst_n = 1'b1;
        g_if.req_rdy = 1;
        #3;
        got = {g_if.req_vld, h0_if.req_rdy, h1_if.req_rdy, g_if.rsp_rdy, h0_if.rsp_vld, h1_if.rsp_vld};
        checks++;
        if (got !== 6'b110000) begin
            failures++;
            $display("FAIL midreset_after: got %b expected 110000", got);
        end
        $display("test_reset_mid: outputs after release %b", got);
        set_idle();
        next_cycle();
    endtask

    task automatic test_random();
        logic v0, v1, grdy, gv, r0, r1;
        logic [31:0] a0, a1, d0, d1, rd;
        logic w0, w1;
        logic [3:0] s0, s1;
        int gsel, head;
        bit full, empty, e_gvld, e_grsprdy;
        logic [5:0] got_c, exp_c;
        logic [68:0] got_p, exp_p;
        apply_reset();
        for (int k = 0; k < 400; k++) begin
            v0 = ($urandom_range(0, 9) < 7); v1 = ($urandom_range(0, 9) < 7);
            if (m_lock == 0) v0 = 1;
            if (m_lock == 1) v1 = 1;
            grdy = ($urandom_range(0, 9) < 6); gv = ($urandom_range(0, 9) < 4);
            r0 = ($urandom_range(0, 9) < 7); r1 = ($urandom_range(0, 9) < 7);
            a0 = $urandom; a1 = $urandom; d0 = $urandom; d1 = $urandom; rd = $urandom;
            w0 = $urandom_range(0, 1); w1 = $urandom_range(0, 1);
            s0 = $urandom_range(0, 15); s1 = $urandom_range(0, 15);
            h0_if.req_vld = v0; h0_if.req_addr = a0; h0_if.req_wr = w0; h0_if.req_wdata = d0; h0_if.req_strb = s0; h0_if.rsp_rdy = r0;
            h1_if.req_vld = v1; h1_if.req_addr = a1; h1_if.req_wr = w1; h1_if.req_wdata = d1; h1_if.req_strb = s1; h1_if.rsp_rdy = r1;
            g_if.req_rdy = grdy; g_if.rsp_vld = gv; g_if.rsp_rdata = rd;

            full  = (m_q.size() == DEPTH);
            empty = (m_q.size() == 0);
            if (m_lock >= 0) gsel = m_lock;
            else if (v0 && v1) gsel = RR ? m_prio : 0;
            else gsel = v1 ? 1 : 0;
            head = empty ? 0 : m_q[0];
            e_gvld    = !full && ((gsel == 1) ? v1 : v0);
            e_grsprdy = !empty && ((head == 1) ? r1 : r0);
            exp_c = {e_gvld, gsel == 0 && grdy && !full, gsel == 1 && grdy && !full,
                     e_grsprdy, gv && !empty && head == 0, gv && !empty && head == 1};
            exp_p = (gsel == 1) ? {a1, w1, d1, s1} : {a0, w0, d0, s0};
            #3;
            got_c = {g_if.req_vld, h0_if.req_rdy, h1_if.req_rdy, g_if.rsp_rdy, h0_if.rsp_vld, h1_if.rsp_vld};
            got_p = {g_if.req_addr, g_if.req_wr, g_if.req_wdata, g_if.req_strb};
            checks++;
            if (got_c !== exp_c || got_p !== exp_p || h0_if.rsp_rdata !== rd || h1_if.rsp_rdata !== rd) begin
                failures++;
                $display("FAIL random[%0d]: got ctl=%b pay=%h rdata=%h/%h expected ctl=%b pay=%h rdata=%h",
                         k, got_c, got_p, h0_if.rsp_rdata, h1_if.rsp_rdata, exp_c, exp_p, rd);
            end
            $display("test_random: cycle %0d host=%0d ostd=%0d ctl=%b", k, gsel, m_q.size(), got_c);
            if (gv && e_grsprdy) void'(m_q.pop_front());
            if (e_gvld && grdy) begin
                m_q.push_back(gsel);
                m_prio = 1 - gsel;
                m_lock = -1;
            end else if (e_gvld) begin
                m_lock = gsel;
            end
            next_cycle();
        end
        set_idle();
    endtask

    initial begin
        set_idle();
        test_reset();
        test_contention();
        test_lock();
        test_ostd_full();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end
endmodule
